// File: rtl/rv32i_types.sv
// Shared RV32I types for the fetch stage and its branch predictor.
//   bp_mode_t       : prediction mode selected at elaboration time
//   rv32i_opcode    : major opcodes (instr[6:0]) that the fetch stage inspects
//   ctrl_flow_preds : prediction record carried down the pipe with each fetch
//   sat_cnt_update  : 2-bit saturating counter step
package rv32i_types;

    typedef enum logic [1:0] {
        BP_STATIC_NT = 2'd0,
        BP_BTFNT     = 2'd1,
        BP_BIMODAL   = 2'd2
    } bp_mode_t;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef struct packed {
        logic staticNT_pred;     // static not-taken: always 0
        logic staticBTFNT_pred;  // backward-taken / forward-not-taken on a hit
        logic dyn_pred;          // taken decision of the active mode
    } ctrl_flow_preds;

    localparam logic [1:0] CNT_RESET     = 2'b01;  // weakly not-taken
    localparam logic [1:0] CNT_NEW_TAKEN = 2'b10;  // fresh entry, weakly taken
    localparam logic [1:0] CNT_NEW_NT    = 2'b01;  // fresh entry, weakly not-taken

    function automatic logic [1:0] sat_cnt_update(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB plus 2-bit counter array.
//   lookup port : lkp_pc -> lkp_hit / lkp_target / lkp_cnt (combinational)
//   update port : upd_valid, upd_pc, upd_target, upd_taken (written at the edge)
// Index is pc[IDX+1:2], tag is pc[31:IDX+2]. A lookup and an update to the same
// entry in one cycle see the pre-update contents, since reads are combinational
// from the registered arrays.
module bp_table
    import rv32i_types::*;
#(
    parameter int unsigned BP_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lkp_pc,
    output logic        lkp_hit,
    output logic [31:0] lkp_target,
    output logic [1:0]  lkp_cnt,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken
);

    localparam int IDX   = $clog2(BP_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    logic [BP_ENTRIES-1:0] valid_q;
    logic [1:0]            cnt_q    [BP_ENTRIES];
    logic [TAG_W-1:0]      tag_q    [BP_ENTRIES];
    logic [31:0]           target_q [BP_ENTRIES];

    logic [IDX-1:0]   lkp_idx, upd_idx;
    logic [TAG_W-1:0] lkp_tag, upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_cnt_next;
    logic             unused_pc_bits;

    assign lkp_idx = lkp_pc[IDX+1:2];
    assign lkp_tag = lkp_pc[31:IDX+2];
    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[31:IDX+2];
    assign unused_pc_bits = ^{lkp_pc[1:0], upd_pc[1:0]};

    assign lkp_hit    = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign lkp_target = target_q[lkp_idx];
    assign lkp_cnt    = cnt_q[lkp_idx];

    // An update whose tag misses replaces the entry and restarts its counter
    // at the weak state matching the resolved direction.
    assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_cnt_next = upd_hit ? sat_cnt_update(cnt_q[upd_idx], upd_taken)
                                  : (upd_taken ? CNT_NEW_TAKEN : CNT_NEW_NT);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(BP_ENTRIES); i++)
                cnt_q[i] <= CNT_RESET;
        end else if (upd_valid) begin
            valid_q[upd_idx] <= 1'b1;
            cnt_q[upd_idx]   <= upd_cnt_next;
        end
    end

    // NOTE: tag and target storage is deliberately not reset; nothing reads it
    // as meaningful until the matching valid bit has been set by an update.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid) begin
            tag_q[upd_idx] <= upd_tag;
            if (upd_taken)
                target_q[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/pc_register.sv
// Fetch PC register with synchronous active-high reset.
//   clk, rst : clock, synchronous reset (loads RESET_VALUE)
//   load     : capture d at the edge, otherwise hold
//   d / q    : next PC / current PC
module pc_register #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_VALUE;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/if_fetch_bp.sv
// Instruction-fetch stage with branch prediction.
//   clk, rst          : clock, synchronous active-high reset
//   pc_write_i        : advance the PC (0 = stall)
//   instr_rdata_i     : instruction at pc_o, decoded for the BTFNT rule
//   redirect_i/_pc_i  : flush from EX with the correct next PC
//   upd_*             : resolved branch/jump training the predictor
//   pc_o / next_pc_o  : current fetch PC / PC loaded at the next edge
//   pred_o            : prediction record for the pipe
//   pred_target_o     : predicted target (entry target on a hit, else pc+4)
//   mispredict_cnt_o  : saturating count of redirect cycles since reset
module if_fetch_bp
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0060,
    parameter int unsigned BP_ENTRIES = 16,
    parameter bp_mode_t    BP_MODE    = BP_BIMODAL
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pc_write_i,
    input  logic [31:0]    instr_rdata_i,
    input  logic           redirect_i,
    input  logic [31:0]    redirect_pc_i,
    input  logic           upd_valid_i,
    input  logic [31:0]    upd_pc_i,
    input  logic [31:0]    upd_target_i,
    input  logic           upd_taken_i,
    output logic [31:0]    pc_o,
    output logic [31:0]    next_pc_o,
    output ctrl_flow_preds pred_o,
    output logic [31:0]    pred_target_o,
    output logic [31:0]    mispredict_cnt_o
);

    logic        lkp_hit;
    logic [31:0] lkp_target;
    logic [1:0]  lkp_cnt;
    logic [31:0] pc_plus4;
    logic [6:0]  opcode;
    logic        btfnt_rule;
    logic        mode_rule;
    logic        pred_taken;
    logic        unused_instr_bits;

    bp_table #(
        .BP_ENTRIES (BP_ENTRIES)
    ) u_bp_table (
        .clk        (clk),
        .rst        (rst),
        .lkp_pc     (pc_o),
        .lkp_hit    (lkp_hit),
        .lkp_target (lkp_target),
        .lkp_cnt    (lkp_cnt),
        .upd_valid  (upd_valid_i),
        .upd_pc     (upd_pc_i),
        .upd_target (upd_target_i),
        .upd_taken  (upd_taken_i)
    );

    assign pc_plus4 = pc_o + 32'd4;
    assign opcode   = instr_rdata_i[6:0];
    assign unused_instr_bits = ^{instr_rdata_i[30:7], redirect_pc_i[0]};

    // Conditional branches with a negative offset (sign bit set) are loops
    // and predicted taken; unconditional jumps are always taken.
    assign btfnt_rule = ((opcode == op_br) && instr_rdata_i[31])
                      || (opcode == op_jal) || (opcode == op_jalr);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        mode_rule = 1'b0;
        case (BP_MODE)
            BP_BTFNT:   mode_rule = btfnt_rule;
            BP_BIMODAL: mode_rule = lkp_cnt[1];
            default:    mode_rule = 1'b0;
        endcase
    end

    assign pred_taken = lkp_hit && mode_rule;

    assign pred_o.staticNT_pred    = 1'b0;
    assign pred_o.staticBTFNT_pred = lkp_hit && btfnt_rule;
    assign pred_o.dyn_pred         = pred_taken;

    assign pred_target_o = lkp_hit ? lkp_target : pc_plus4;

    always_comb begin
        if (redirect_i)
            next_pc_o = {redirect_pc_i[31:1], 1'b0};
        else if (pred_taken)
            next_pc_o = lkp_target;
        else
            next_pc_o = pc_plus4;
    end

    // A redirect must land even while the front end is stalled.
    pc_register #(
        .RESET_VALUE (RESET_PC)
    ) u_pc_register (
        .clk  (clk),
        .rst  (rst),
        .load (redirect_i | pc_write_i),
        .d    (next_pc_o),
        .q    (pc_o)
    );

    always_ff @(posedge clk) begin
        if (rst)
            mispredict_cnt_o <= '0;
        else if (redirect_i && (mispredict_cnt_o != 32'hFFFF_FFFF))
            mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
    end

endmodule

// File: tb/tb_if_fetch_bp.sv
// Scoreboard bench for if_fetch_bp. Three instances (BIMODAL, BTFNT,
// STATIC_NT) share one stimulus stream; the driver pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_if_fetch_bp;
    import rv32i_types::*;

    localparam int I_BIM = 0;
    localparam int I_BTF = 1;
    localparam int I_SNT = 2;

    localparam int S_PC    = 0;
    localparam int S_NPC   = 1;
    localparam int S_TGT   = 2;
    localparam int S_DYN   = 3;
    localparam int S_BTFNT = 4;
    localparam int S_SNT   = 5;
    localparam int S_CNT   = 6;

    localparam logic [31:0] I_BACK_BR = 32'h8000_0063;
    localparam logic [31:0] I_FWD_BR  = 32'h0000_0063;
    localparam logic [31:0] I_JAL     = 32'h0000_006F;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic [31:0] instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;

    logic [31:0]    pc_v   [3];
    logic [31:0]    npc_v  [3];
    ctrl_flow_preds pred_v [3];
    logic [31:0]    tgt_v  [3];
    logic [31:0]    cnt_v  [3];

    int checks   = 0;
    int failures = 0;

    string       name_q[$];
    int          inst_q[$];
    int          sig_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    if_fetch_bp #(.BP_MODE(BP_BIMODAL)) u_bim (
        .clk(clk), .rst(rst), .pc_write_i(pc_write), .instr_rdata_i(instr),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_target_i(upd_target),
        .upd_taken_i(upd_taken), .pc_o(pc_v[0]), .next_pc_o(npc_v[0]),
        .pred_o(pred_v[0]), .pred_target_o(tgt_v[0]), .mispredict_cnt_o(cnt_v[0])
    );

    if_fetch_bp #(.BP_MODE(BP_BTFNT)) u_btf (
        .clk(clk), .rst(rst), .pc_write_i(pc_write), .instr_rdata_i(instr),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_target_i(upd_target),
        .upd_taken_i(upd_taken), .pc_o(pc_v[1]), .next_pc_o(npc_v[1]),
        .pred_o(pred_v[1]), .pred_target_o(tgt_v[1]), .mispredict_cnt_o(cnt_v[1])
    );

    if_fetch_bp #(.BP_MODE(BP_STATIC_NT)) u_snt (
        .clk(clk), .rst(rst), .pc_write_i(pc_write), .instr_rdata_i(instr),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_target_i(upd_target),
        .upd_taken_i(upd_taken), .pc_o(pc_v[2]), .next_pc_o(npc_v[2]),
        .pred_o(pred_v[2]), .pred_target_o(tgt_v[2]), .mispredict_cnt_o(cnt_v[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_actual(input int inst, input int sig);
        case (sig)
            S_PC:    return pc_v[inst];
            S_NPC:   return npc_v[inst];
            S_TGT:   return tgt_v[inst];
            S_DYN:   return {31'd0, pred_v[inst].dyn_pred};
            S_BTFNT: return {31'd0, pred_v[inst].staticBTFNT_pred};
            S_SNT:   return {31'd0, pred_v[inst].staticNT_pred};
            default: return cnt_v[inst];
        endcase
    endfunction

    // Monitor: outputs are stable mid-cycle, so compare at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (name_q.size() > 0) begin
                string       n;
                int          inst;
                int          sig;
                logic [31:0] e;
                n    = name_q.pop_front();
                inst = inst_q.pop_front();
                sig  = sig_q.pop_front();
                e    = exp_q.pop_front();
                check($sformatf("%s[%0d]", n, inst), get_actual(inst, sig), e);
            end
        end
    end

    task automatic expect1(input string name, input int inst, input int sig, input logic [31:0] e);
        name_q.push_back(name);
        inst_q.push_back(inst);
        sig_q.push_back(sig);
        exp_q.push_back(e);
    endtask

    task automatic expect3(input string name, input int sig, input logic [31:0] e);
        for (int i = 0; i < 3; i++)
            expect1(name, i, sig, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        upd_valid  = v;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
    endtask

    initial begin
        rst = 1'b1; pc_write = 1'b1; instr = I_FWD_BR;
        redirect = 1'b0; redirect_pc = '0;
        set_upd(1'b0, '0, '0, 1'b0);

        // Reset held two cycles, then free-running fetch.
        step(); step();
        rst = 1'b0;
        expect3("rst_pc", S_PC, 32'h60);
        expect3("rst_npc", S_NPC, 32'h64);
        expect3("rst_cnt", S_CNT, 32'd0);
        expect3("rst_dyn", S_DYN, 32'd0);
        step();
        expect3("seq_pc1", S_PC, 32'h64);
        step();
        expect3("seq_pc2", S_PC, 32'h68);

        // Two taken updates for 0x80 while stalled: updates ignore the stall.
        pc_write = 1'b0;
        set_upd(1'b1, 32'h80, 32'h200, 1'b1);
        step();
        expect3("stall_hold", S_PC, 32'h68);
        step();
        set_upd(1'b0, '0, '0, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h80;
        expect3("redir_npc", S_NPC, 32'h80);
        step();
        redirect = 1'b0;
        instr = I_BACK_BR;
        expect3("at80_pc", S_PC, 32'h80);
        expect3("at80_cnt", S_CNT, 32'd1);
        expect1("bim_taken_npc", I_BIM, S_NPC, 32'h200);
        expect1("bim_taken_dyn", I_BIM, S_DYN, 32'd1);
        expect1("bim_taken_tgt", I_BIM, S_TGT, 32'h200);
        expect1("btf_back_npc", I_BTF, S_NPC, 32'h200);
        expect1("snt_npc", I_SNT, S_NPC, 32'h84);
        expect1("snt_dyn", I_SNT, S_DYN, 32'd0);
        expect1("snt_tgt", I_SNT, S_TGT, 32'h200);
        expect3("back_btfnt_bit", S_BTFNT, 32'd1);
        expect3("snt_bit", S_SNT, 32'd0);
        step();

        // Forward branch: BTFNT falls through, BIMODAL still taken.
        instr = I_FWD_BR;
        expect1("bim_fwd_npc", I_BIM, S_NPC, 32'h200);
        expect1("btf_fwd_npc", I_BTF, S_NPC, 32'h84);
        expect1("btf_fwd_dyn", I_BTF, S_DYN, 32'd0);
        expect3("fwd_btfnt_bit", S_BTFNT, 32'd0);
        step();
        instr = I_JAL;
        expect1("btf_jal_npc", I_BTF, S_NPC, 32'h200);
        step();

        // Read-before-write: same-cycle update is invisible to the lookup.
        instr = I_BACK_BR;
        set_upd(1'b1, 32'h80, 32'h400, 1'b1);
        expect1("rbw_bim_npc", I_BIM, S_NPC, 32'h200);
        expect1("rbw_btf_npc", I_BTF, S_NPC, 32'h200);
        step();
        set_upd(1'b1, 32'h80, 32'hDEAD_BEE0, 1'b0);
        expect1("newtgt_bim_npc", I_BIM, S_NPC, 32'h400);
        expect1("newtgt_btf_npc", I_BTF, S_NPC, 32'h400);
        step();
        // Counter saturated at 3 -> one not-taken leaves it at 2 (still taken).
        expect1("nt1_bim_npc", I_BIM, S_NPC, 32'h400);
        expect1("nt1_bim_dyn", I_BIM, S_DYN, 32'd1);
        step();
        set_upd(1'b0, '0, '0, 1'b0);
        expect1("nt2_bim_npc", I_BIM, S_NPC, 32'h84);
        expect1("nt2_bim_dyn", I_BIM, S_DYN, 32'd0);
        expect1("nt2_bim_tgt", I_BIM, S_TGT, 32'h400);
        expect1("nt2_btf_npc", I_BTF, S_NPC, 32'h400);
        step();

        // 0xC0 shares index 0 with 0x80 but carries a different tag.
        redirect = 1'b1; redirect_pc = 32'hC0;
        step();
        redirect = 1'b0;
        expect3("alias_pc", S_PC, 32'hC0);
        expect3("alias_npc", S_NPC, 32'hC4);
        expect3("alias_tgt", S_TGT, 32'hC4);
        expect3("alias_btfnt_bit", S_BTFNT, 32'd0);
        expect3("alias_cnt", S_CNT, 32'd2);
        set_upd(1'b1, 32'hC0, 32'h700, 1'b0);
        step();
        // Entry now owned by 0xC0, counter 01, target left stale at 0x400.
        set_upd(1'b1, 32'h80, 32'h600, 1'b1);
        expect1("repl_bim_npc", I_BIM, S_NPC, 32'hC4);
        expect1("repl_bim_tgt", I_BIM, S_TGT, 32'h400);
        expect1("repl_btf_npc", I_BTF, S_NPC, 32'h400);
        step();
        set_upd(1'b0, '0, '0, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h81;
        expect3("odd_redir_npc", S_NPC, 32'h80);
        step();
        redirect = 1'b0;
        // Tag-miss taken update restarted the counter at 2'b10.
        set_upd(1'b1, 32'h80, 32'h600, 1'b0);
        expect1("miss_init_bim_npc", I_BIM, S_NPC, 32'h600);
        expect1("miss_init_btf_npc", I_BTF, S_NPC, 32'h600);
        expect3("miss_init_cnt", S_CNT, 32'd3);
        step();
        set_upd(1'b0, '0, '0, 1'b0);
        expect1("miss_dec_bim_npc", I_BIM, S_NPC, 32'h84);
        step();

        // Redirect overrides a stall; LSB of the redirect PC is cleared.
        pc_write = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h301;
        expect3("stall_redir_npc", S_NPC, 32'h300);
        step();
        redirect = 1'b0;
        expect3("stall_redir_pc", S_PC, 32'h300);
        expect3("stall_redir_cnt", S_CNT, 32'd4);
        step();

        // Reset dominates redirect, update and pc_write; table is invalidated.
        rst = 1'b1; pc_write = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h80;
        set_upd(1'b1, 32'h300, 32'h900, 1'b1);
        step();
        rst = 1'b0; pc_write = 1'b0; redirect = 1'b0;
        set_upd(1'b0, '0, '0, 1'b0);
        expect3("rst2_pc", S_PC, 32'h60);
        expect3("rst2_cnt", S_CNT, 32'd0);
        step();
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        expect3("rst2_miss_npc", S_NPC, 32'h84);
        expect3("rst2_miss_tgt", S_TGT, 32'h84);
        expect3("rst2_miss_dyn", S_DYN, 32'd0);
        expect3("rst2_cnt1", S_CNT, 32'd1);
        step();

        repeat (3) @(posedge clk);
        check("sb_drain", name_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
